// File: rtl/udp_tx_pkt_scheduler_if.sv
// Byte-stream, FIFO and UDP-stack handshake signals of the UDP TX packet scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface udp_tx_pkt_scheduler_if #(
   parameter int LEN_W = 16
);
   logic             src_valid;
   logic [7:0]       src_data;
   logic             src_last;
   logic             src_ready;

   logic             fifo_wr_en;
   logic [7:0]       fifo_wr_data;
   logic             fifo_wr_vld;
   logic             fifo_rd_en;
   logic             fifo_rd_vld;
   logic [7:0]       fifo_rd_data;

   logic             udp_tx_req;
   logic [LEN_W-1:0] udp_tx_len;
   logic             udp_tx_ack;
   logic             udp_data_req;
   logic [7:0]       udp_tx_data;
   logic             udp_tx_data_vld;
   logic             err_underrun;

   modport master (
      input  src_valid, src_data, src_last,
      input  fifo_wr_vld, fifo_rd_vld, fifo_rd_data,
      input  udp_tx_ack, udp_data_req,
      output src_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en,
      output udp_tx_req, udp_tx_len, udp_tx_data, udp_tx_data_vld, err_underrun
   );

   modport slave (
      output src_valid, src_data, src_last,
      output fifo_wr_vld, fifo_rd_vld, fifo_rd_data,
      output udp_tx_ack, udp_data_req,
      input  src_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en,
      input  udp_tx_req, udp_tx_len, udp_tx_data, udp_tx_data_vld, err_underrun
   );
endinterface

// File: rtl/udp_tx_pkt_scheduler.sv
// Cuts the source byte stream into UDP payloads, queues their lengths, and drains
// each payload from the external byte FIFO on the UDP stack's byte requests.
module udp_tx_pkt_scheduler #(
   parameter int PKT_LEN      = 1024,
   parameter int LEN_W        = 16,
   parameter int LENQ_DEPTH_W = 2,
   parameter int IPG_CYCLES   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   udp_tx_pkt_scheduler_if.master bus
);
   localparam int LENQ_DEPTH = 1 << LENQ_DEPTH_W;
   localparam logic [LEN_W-1:0] PKT_LAST = LEN_W'(PKT_LEN - 1);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
   localparam logic [LENQ_DEPTH_W:0] LENQ_FULL_CNT = (LENQ_DEPTH_W+1)'(LENQ_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t state_reg, state_next;

   // Write side
   logic             src_ready;
   logic             wr_accept;
   logic             pkt_close;
   logic [LEN_W-1:0] wr_cnt_reg, wr_cnt_next;

   // Pending-length queue
   logic [LEN_W-1:0]        lenq_mem [LENQ_DEPTH];
   logic [LENQ_DEPTH_W-1:0] lenq_wr_ptr_reg, lenq_rd_ptr_reg;
   logic [LENQ_DEPTH_W:0]   lenq_cnt_reg;
   logic                    lenq_full, lenq_empty, lenq_push, lenq_pop;
   logic [LEN_W-1:0]        lenq_head;
   logic [LEN_W-1:0]        lenq_push_len;

   // Read side
   logic             rd_pop;
   logic [LEN_W-1:0] rd_cnt_reg, rd_cnt_next;
   logic [LEN_W-1:0] tx_len_reg, tx_len_next;
   logic             tx_req_reg, tx_req_next;
   logic [7:0]       tx_data_reg, tx_data_next;
   logic             tx_data_vld_reg, tx_data_vld_next;
   logic             err_underrun_reg, err_underrun_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

   // A full length queue stalls every write so a boundary push always has a slot.
   assign lenq_full  = (lenq_cnt_reg == LENQ_FULL_CNT);
   assign lenq_empty = (lenq_cnt_reg == '0);
   assign src_ready  = bus.fifo_wr_vld & ~lenq_full;
   assign wr_accept  = bus.src_valid & src_ready;
   assign pkt_close  = wr_accept & (bus.src_last | (wr_cnt_reg == PKT_LAST));

   assign lenq_push     = pkt_close;
   assign lenq_push_len = wr_cnt_reg + LEN_ONE;
   assign lenq_head     = lenq_mem[lenq_rd_ptr_reg];

   always_comb begin
      wr_cnt_next = wr_cnt_reg;
      if (pkt_close) begin
         wr_cnt_next = '0;
      end else if (wr_accept) begin
         wr_cnt_next = wr_cnt_reg + LEN_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_reg <= '0;
      end else begin
         wr_cnt_reg <= wr_cnt_next;
      end
   end

   generate
      for (genvar gi = 0; gi < LENQ_DEPTH; gi++) begin : g_lenq
         logic [LEN_W-1:0] entry_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (lenq_push && (lenq_wr_ptr_reg == LENQ_DEPTH_W'(gi))) begin
               entry_reg <= lenq_push_len;
            end
         end

         assign lenq_mem[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lenq_wr_ptr_reg <= '0;
         lenq_rd_ptr_reg <= '0;
         lenq_cnt_reg    <= '0;
      end else begin
         if (lenq_push) begin
            lenq_wr_ptr_reg <= lenq_wr_ptr_reg + 1'b1;
         end
         if (lenq_pop) begin
            lenq_rd_ptr_reg <= lenq_rd_ptr_reg + 1'b1;
         end
         case ({lenq_push, lenq_pop})
            2'b10:   lenq_cnt_reg <= lenq_cnt_reg + 1'b1;
            2'b01:   lenq_cnt_reg <= lenq_cnt_reg - 1'b1;
            default: lenq_cnt_reg <= lenq_cnt_reg;
         endcase
      end
   end

   always_comb begin
      state_next        = state_reg;
      rd_cnt_next       = rd_cnt_reg;
      tx_len_next       = tx_len_reg;
      tx_data_next      = tx_data_reg;
      tx_data_vld_next  = 1'b0;
      err_underrun_next = err_underrun_reg;
      gap_cnt_next      = gap_cnt_reg;
      rd_pop            = 1'b0;
      lenq_pop          = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!lenq_empty) begin
               state_next  = ST_REQ;
               tx_len_next = lenq_head;
               rd_cnt_next = lenq_head;
            end
         end
         ST_REQ: begin
            if (bus.udp_tx_ack) begin
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.udp_data_req) begin
               if (bus.fifo_rd_vld) begin
                  rd_pop           = 1'b1;
                  tx_data_next     = bus.fifo_rd_data;
                  tx_data_vld_next = 1'b1;
                  rd_cnt_next      = rd_cnt_reg - LEN_ONE;
                  // The head entry stays queued until its last byte leaves.
                  if (rd_cnt_reg == LEN_ONE) begin
                     lenq_pop     = 1'b1;
                     state_next   = ST_GAP;
                     gap_cnt_next = '0;
                  end
               end else begin
                  err_underrun_next = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      tx_req_next = (state_next == ST_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         rd_cnt_reg       <= '0;
         tx_len_reg       <= '0;
         tx_req_reg       <= 1'b0;
         tx_data_reg      <= '0;
         tx_data_vld_reg  <= 1'b0;
         err_underrun_reg <= 1'b0;
         gap_cnt_reg      <= '0;
      end else begin
         state_reg        <= state_next;
         rd_cnt_reg       <= rd_cnt_next;
         tx_len_reg       <= tx_len_next;
         tx_req_reg       <= tx_req_next;
         tx_data_reg      <= tx_data_next;
         tx_data_vld_reg  <= tx_data_vld_next;
         err_underrun_reg <= err_underrun_next;
         gap_cnt_reg      <= gap_cnt_next;
      end
   end

   assign bus.src_ready       = src_ready;
   assign bus.fifo_wr_en      = wr_accept;
   assign bus.fifo_wr_data    = bus.src_data;
   assign bus.fifo_rd_en      = rd_pop;
   assign bus.udp_tx_req      = tx_req_reg;
   assign bus.udp_tx_len      = tx_len_reg;
   assign bus.udp_tx_data     = tx_data_reg;
   assign bus.udp_tx_data_vld = tx_data_vld_reg;
   assign bus.err_underrun    = err_underrun_reg;

endmodule
